// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the icache, dcache and RAM-side signals of the
// memory arbiter.
//   master : the arbiter's view. It drives iwait/iload, dwait/dload and the
//            RAM strobes, address and store data, and it receives the
//            requests, ramload and ramstate.
//   slave  : the environment's view (caches plus RAM), with every direction
//            reversed.
interface mem_arbiter_if;
    localparam int unsigned WORD_W = 32;

    // icache side
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;

    // dcache side
    logic              dREN;
    logic              dWEN;
    logic [WORD_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              dwait;
    logic [WORD_W-1:0] dload;

    // RAM side
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload;
    logic [1:0]        ramstate;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single RAM port between an icache and a dcache.
// The arbiter grants one side at a time. It holds that grant until the RAM
// reports ACCESS, or until the granted side drops its request.
//   CLK  : system clock, rising edge.
//   nRST : asynchronous, active-low reset.
//   bus  : mem_arbiter_if.master. It carries the icache request/stall/data,
//          the dcache request/stall/data, the RAM strobes, address and store
//          data, ramload, and ramstate (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR).
// Configuration:
//   ARB_ROUND_ROBIN_EN : when defined, a tie goes to the side that was not
//                        granted last. When undefined, the dcache always
//                        wins a tie.
module mem_arbiter (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.master bus
);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } state_t;

    state_t state;
    state_t arb_state;
    logic   armed;
    logic   d_req;
    logic   i_req;
    logic   access;
    logic   rearb;

    assign d_req  = bus.dREN | bus.dWEN;
    assign i_req  = bus.iREN;
    assign access = (bus.ramstate == RAM_ACCESS);

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the dcache holds the most recent grant. Reset means the icache
    // was served last, so the first tie goes to the dcache.
    logic last_d;

    always_comb begin
        arb_state = IDLE;
        if (d_req && i_req) begin
            arb_state = last_d ? ISERV : DSERV;
        end else if (d_req) begin
            arb_state = DSERV;
        end else if (i_req) begin
            arb_state = ISERV;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_d <= 1'b0;
        end else if (rearb && (arb_state != IDLE)) begin
            last_d <= (arb_state == DSERV);
        end
    end
`else
    // Fixed priority: the dcache wins whenever it requests.
    always_comb begin
        arb_state = IDLE;
        if (d_req) begin
            arb_state = DSERV;
        end else if (i_req) begin
            arb_state = ISERV;
        end
    end
`endif

    // The grant may move only when the current transfer completes, when the
    // granted side gives up its request, or from IDLE once the arbiter is armed.
    always_comb begin
        rearb = 1'b0;
        unique case (state)
            IDLE:    rearb = armed;
            DSERV:   rearb = !d_req || access;
            ISERV:   rearb = !i_req || access;
            default: rearb = 1'b1;
        endcase
    end

    // State register. 'armed' blocks arbitration on the first edge after
    // reset, so the earliest grant lands on the second edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (rearb) begin
                state <= arb_state;
            end
        end
    end

    // Outputs decode the state combinationally, so an asynchronous reset
    // forces the idle values at once. A stall drops only in an ACCESS cycle
    // of a request that is still live.
    always_comb begin
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        unique case (state)
            DSERV: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.dwait    = ~(access & d_req);
                bus.dload    = bus.ramload;
            end
            ISERV: begin
                bus.ramaddr  = bus.iaddr;
                bus.ramREN   = bus.iREN;
                bus.iwait    = ~(access & i_req);
                bus.iload    = bus.ramload;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. Requester tasks queue the
// expected completions. A negedge monitor pops the queue whenever a stall
// drops, and it checks the per-cycle arbitration rules.
module tb_mem_arbiter;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
    } txn_t;

    logic CLK = 1'b0;
    logic nRST;
    mem_arbiter_if bus ();
    mem_arbiter dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    txn_t        i_exp[$];
    txn_t        d_exp[$];
    logic [31:0] ram_mem[logic [31:0]];
    logic [31:0] shadow[logic [31:0]];
    logic [7:0]  order_q[$];
    logic [7:0]  exp_order[$];
    int          n_pass = 0;
    int          n_checks = 0;
    int          i_done = 0;
    int          d_done = 0;
    int          ram_mode = 0;          // 0 scripted, 1 random, 2 ACCESS every 2nd cycle
    logic [1:0]  ram_cmd = FREE;
    bit          seen;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Default RAM contents for a word that has never been written
    function automatic logic [31:0] pat(logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    // RAM model: it picks ramstate for each cycle, then returns the word at ramaddr.
    task automatic ram_loop();
        forever begin
            @(posedge CLK);
            #2;
            if (ram_mode == 1) begin
                case ($urandom_range(0, 5))
                    0, 1, 2: bus.ramstate = ACCESS;
                    3:       bus.ramstate = BUSY;
                    4:       bus.ramstate = FREE;
                    default: bus.ramstate = ERROR;
                endcase
            end else if (ram_mode == 2) begin
                bus.ramstate = (bus.ramstate == ACCESS) ? BUSY : ACCESS;
            end else begin
                bus.ramstate = ram_cmd;
            end
            #1;
            bus.ramload = ram_mem.exists(bus.ramaddr) ? ram_mem[bus.ramaddr] : pat(bus.ramaddr);
        end
    endtask

    // Monitor: checks the invariants every cycle and pops the scoreboard on each completion.
    task automatic monitor();
        txn_t e;
        forever begin
            @(negedge CLK);
            if (nRST === 1'b1) begin
                chk("dual_complete", 32'(!bus.iwait && !bus.dwait), 32'd0);
                if (bus.ramstate != ACCESS)
                    chk("wait_outside_access", 32'({bus.iwait, bus.dwait}), 32'd3);
                if (!bus.iwait) begin
                    chk("i_pending", 32'(i_exp.size() != 0), 32'd1);
                    if (i_exp.size() != 0) begin
                        e = i_exp.pop_front();
                        chk("i_ramaddr", bus.ramaddr, e.addr);
                        chk("i_strobes", 32'({bus.ramREN, bus.ramWEN}), 32'd2);
                        chk("i_load", bus.iload, e.data);
                        chk("i_dload_zero", bus.dload, 32'd0);
                    end
                    order_q.push_back("I");
                    i_done++;
                end
                if (!bus.dwait) begin
                    chk("d_pending", 32'(d_exp.size() != 0), 32'd1);
                    if (d_exp.size() != 0) begin
                        e = d_exp.pop_front();
                        chk("d_ramaddr", bus.ramaddr, e.addr);
                        chk("d_strobes", 32'({bus.ramREN, bus.ramWEN}), e.wr ? 32'd1 : 32'd2);
                        if (e.wr) chk("d_ramstore", bus.ramstore, e.data);
                        else      chk("d_load", bus.dload, e.data);
                        chk("d_iload_zero", bus.iload, 32'd0);
                    end
                    order_q.push_back("D");
                    d_done++;
                end
                if (bus.ramstate == ACCESS && bus.ramWEN) ram_mem[bus.ramaddr] = bus.ramstore;
            end
        end
    endtask

    task automatic put_i(logic [31:0] a, logic [31:0] d);
        bus.iaddr = a;
        bus.iREN  = 1'b1;
        i_exp.push_back('{addr: a, data: d, wr: 1'b0});
    endtask

    task automatic put_d(logic [31:0] a, logic [31:0] d, logic wen, logic ren);
        bus.daddr  = a;
        bus.dstore = d;
        bus.dWEN   = wen;
        bus.dREN   = ren;
        if (wen) shadow[a] = d;
        d_exp.push_back('{addr: a, data: wen ? d : (shadow.exists(a) ? shadow[a] : pat(a)), wr: wen});
    endtask

    // Scripted RAM: state st for n cycles from the grant, then one ACCESS
    // cycle. All requests are released after that.
    task automatic serve(logic [1:0] st, int n, logic [1:0] strobe, logic [31:0] addr);
        bit g = 1'b0;
        for (int c = 0; c < 10 && !g; c++) begin
            @(negedge CLK);
            g = bus.ramREN | bus.ramWEN;
        end
        chk("grant_seen", 32'(g), 32'd1);
        for (int c = 1; c < n; c++) begin
            @(posedge CLK); #1; ram_cmd = st;
            @(negedge CLK);
            chk("grant_held_addr", bus.ramaddr, addr);
            chk("grant_held_strobe", 32'({bus.ramREN, bus.ramWEN}), 32'(strobe));
        end
        @(posedge CLK); #1; ram_cmd = ACCESS;
        @(negedge CLK);
        @(posedge CLK); #1; ram_cmd = FREE;
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    endtask

    task automatic i_driver(int n, int max_gap);
        logic [31:0] a;
        bit          done;
        for (int k = 0; k < n; k++) begin
            int gap = $urandom_range(0, max_gap);
            if (gap != 0) begin
                bus.iREN = 1'b0;
                repeat (gap) begin @(posedge CLK); #1; end
            end
            a = {20'h00001, 10'($urandom_range(0, 255)), 2'b00};
            put_i(a, pat(a));
            done = 1'b0;
            for (int c = 0; c < 400 && !done; c++) begin
                @(negedge CLK);
                done = !bus.iwait;
            end
            chk("i_complete_in_time", 32'(done), 32'd1);
            @(posedge CLK); #1;
        end
        bus.iREN = 1'b0;
    endtask

    task automatic d_driver(int n, int max_gap, bit allow_wr);
        logic [31:0] a;
        bit          done;
        bit          w;
        for (int k = 0; k < n; k++) begin
            int gap = $urandom_range(0, max_gap);
            if (gap != 0) begin
                bus.dREN = 1'b0; bus.dWEN = 1'b0;
                repeat (gap) begin @(posedge CLK); #1; end
            end
            a = {24'h000080, 4'($urandom_range(0, 15)), 4'h0};
            w = allow_wr && ($urandom_range(0, 1) == 1);
            if (w) put_d(a, $urandom, 1'b1, 1'($urandom_range(0, 1)));
            else   put_d(a, $urandom, 1'b0, 1'b1);
            done = 1'b0;
            for (int c = 0; c < 400 && !done; c++) begin
                @(negedge CLK);
                done = !bus.dwait;
            end
            chk("d_complete_in_time", 32'(done), 32'd1);
            @(posedge CLK); #1;
        end
        bus.dREN = 1'b0; bus.dWEN = 1'b0;
    endtask

    initial begin
        nRST = 1'b0;
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        bus.dREN = 1'b1; bus.dWEN = 1'b0; bus.daddr = 32'h100; bus.dstore = 32'hFFFF;
        bus.ramstate = FREE; bus.ramload = 32'h1234;
        fork
            monitor();
            ram_loop();
        join_none

        // Outputs stay idle under reset, even with requests raised.
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_strobes", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
        chk("rst_waits", 32'({bus.iwait, bus.dwait}), 32'd3);
        chk("rst_ramaddr", bus.ramaddr, 32'd0);
        chk("rst_ramstore", bus.ramstore, 32'd0);
        chk("rst_loads", bus.iload | bus.dload, 32'd0);
        bus.iREN = 1'b0; bus.dREN = 1'b0;
        @(posedge CLK); #3; nRST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        // icache read: BUSY for two cycles, then ACCESS
        ram_mem[32'h40] = 32'hDEADBEEF;
        ram_cmd = BUSY;
        put_i(32'h40, 32'hDEADBEEF);
        serve(BUSY, 2, 2'b10, 32'h40);
        chk("i_done_single", 32'(i_done), 32'd1);

        // dcache write: ACCESS after one cycle
        ram_cmd = BUSY;
        put_d(32'h3100, 32'h12345678, 1'b1, 1'b0);
        serve(BUSY, 1, 2'b01, 32'h3100);
        chk("d_done_write", 32'(d_done), 32'd1);
        chk("i_idle_during_d", 32'(i_done), 32'd1);
        chk("ram_write_3100", ram_mem.exists(32'h3100) ? ram_mem[32'h3100] : 32'd0, 32'h12345678);

        // dREN and dWEN both set: the write wins
        ram_cmd = BUSY;
        put_d(32'h3104, 32'hCAFEF00D, 1'b1, 1'b1);
        serve(BUSY, 1, 2'b01, 32'h3104);
        chk("ram_write_3104", ram_mem.exists(32'h3104) ? ram_mem[32'h3104] : 32'd0, 32'hCAFEF00D);

        // Reset in the middle of a BUSY dcache write
        ram_cmd = BUSY;
        put_d(32'h3200, 32'h0BADF00D, 1'b1, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge CLK);
            seen = bus.ramWEN;
        end
        chk("grant_before_reset", 32'(seen), 32'd1);
        #2; nRST = 1'b0;
        #1;
        chk("midrst_strobes", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
        chk("midrst_waits", 32'({bus.iwait, bus.dwait}), 32'd3);
        chk("midrst_ramaddr", bus.ramaddr, 32'd0);
        chk("midrst_loads", bus.iload | bus.dload, 32'd0);
        d_exp.delete();
        shadow.delete(32'h3200);
        bus.dWEN = 1'b0; bus.dREN = 1'b0;
        put_i(32'h80, pat(32'h80));
        @(posedge CLK); #3; nRST = 1'b1;
        @(posedge CLK); #1;
        chk("no_grant_edge1", 32'(bus.ramREN), 32'd0);
        @(posedge CLK); #1;
        chk("grant_edge2", 32'(bus.ramREN), 32'd1);
        chk("grant_edge2_addr", bus.ramaddr, 32'h80);
        serve(BUSY, 1, 2'b10, 32'h80);
        chk("i_done_after_reset", 32'(i_done), 32'd2);

        // ERROR for ten cycles: the grant holds and the stall stays up
        ram_cmd = ERROR;
        put_i(32'h44, pat(32'h44));
        serve(ERROR, 10, 2'b10, 32'h44);
        chk("i_done_after_error", 32'(i_done), 32'd3);

        // Both sides request from IDLE, with ACCESS every other cycle
        @(posedge CLK); #1; nRST = 1'b0;
        @(posedge CLK); #1; nRST = 1'b1;
        order_q.delete();
        ram_mode = 2;
        fork
            i_driver(4, 0);
            d_driver(4, 0, 1'b0);
        join
        ram_mode = 0; ram_cmd = FREE;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 4; k++) begin exp_order.push_back("D"); exp_order.push_back("I"); end
`else
        for (int k = 0; k < 4; k++) exp_order.push_back("D");
        for (int k = 0; k < 4; k++) exp_order.push_back("I");
`endif
        chk("order_len", 32'(order_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < order_q.size(); k++)
            chk("grant_order", 32'(order_q[k]), 32'(exp_order[k]));

        // Random traffic on both sides with a random RAM
        ram_mode = 1;
        fork
            i_driver(60, 3);
            d_driver(60, 3, 1'b1);
        join
        ram_mode = 0; ram_cmd = FREE;
        repeat (5) @(posedge CLK);
        #1;
        chk("i_drained", 32'(i_exp.size()), 32'd0);
        chk("d_drained", 32'(d_exp.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, rising edge.
REQ-002 SHALL have ports: nRST  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: iREN  in  1  icache read request.
REQ-004 SHALL have ports: iaddr  in  32  icache word address.
REQ-005 SHALL have ports: iwait  out  1  icache stall; low for exactly the completing cycle.
REQ-006 SHALL have ports: iload  out  32  icache read data.
REQ-007 SHALL have ports: dREN, dWEN  in  1 each  dcache read/write request.
REQ-008 SHALL have ports: daddr, dstore  in  32 each  dcache address / write data.
REQ-009 SHALL have ports: dwait  out  1  dcache stall; low for exactly the completing cycle.
REQ-010 SHALL have ports: dload  out  32  dcache read data.
REQ-011 SHALL have ports: ramREN, ramWEN  out  1 each  RAM strobes.
REQ-012 SHALL have ports: ramaddr, ramstore  out  32 each  RAM address / write data.
REQ-013 SHALL have ports: ramload  in  32  RAM read data.
REQ-014 SHALL have ports: ramstate  in  2  encoding 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
REQ-015 SHALL use one clock; reset SHALL be asynchronous, active-low.

Function
REQ-016 SHALL implement registered FSM, states IDLE, DSERV, ISERV.
REQ-017 IDLE: ram strobes low, ramaddr/ramstore 0, iwait=dwait=1.
REQ-018 IDLE transitions: (dREN|dWEN) -> DSERV; else iREN -> ISERV; else stay; decision in one cycle, grant visible next cycle.
REQ-019 DSERV SHALL drive ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins on dREN&dWEN).
REQ-020 ISERV SHALL drive ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0.
REQ-021 Granted side's wait SHALL be 0 only in a cycle where ramstate==ACCESS; ungranted side's wait SHALL stay 1.
REQ-022 dload=ramload in DSERV, else 0; iload=ramload in ISERV, else 0 (combinational).
REQ-023 BUSY, FREE and ERROR SHALL hold grant and keep wait=1; no timeout.
REQ-024 On ACCESS cycle, FSM SHALL re-arbitrate per REQ-018 (priority per REQ-030/031) using current request lines; back-to-back words to same requester incur no IDLE bubble.
REQ-025 In DSERV/ISERV with granted requester's request low, strobes SHALL be 0 and FSM SHALL re-arbitrate that cycle (next state per REQ-018).
REQ-026 Grant SHALL never change in a cycle where ramstate!=ACCESS and granted request is high (no mid-transaction preemption).
REQ-027 Granted requester changing address/data mid-wait SHALL be passed through unmodified.

Reset
REQ-028 nRST low SHALL immediately force state IDLE and all outputs to REQ-017 values, iload=dload=0, including mid-transaction.
REQ-029 First grant after nRST release SHALL occur no earlier than the second rising edge.

Configuration
REQ-030 Macro ARB_ROUND_ROBIN_EN defined: SHALL keep 1-bit last-served register (reset 0=icache); on re-arbitration with both requesting, grant SHALL go to side not last served.
REQ-031 Macro ARB_ROUND_ROBIN_EN undefined: dcache SHALL always win simultaneous requests; last-served register SHALL not exist.

Verification
REQ-032 Reset, then iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF -> ISERV from cycle 1, iwait low on ACCESS cycle only, iload=0xDEADBEEF.
REQ-033 dWEN=1, daddr=0x3100, dstore=0x12345678, ACCESS after 1 cycle -> ramWEN=1, ramaddr=0x3100, ramstore=0x12345678, dwait=0 one cycle, iwait=1 throughout.
REQ-034 iREN and dREN both high from IDLE, ACCESS every 2nd cycle -> without macro dcache served every transfer until dREN drops; with macro grants alternate D,I,D,I.
REQ-035 dREN=dWEN=1 -> ramWEN=1, ramREN=0.
REQ-036 nRST asserted during DSERV with ramstate BUSY -> same cycle strobes 0, dwait=iwait=1; after release, pending iREN granted on second edge.
REQ-037 ramstate=ERROR for 10 cycles during ISERV then ACCESS -> iwait=1 all 10 cycles, grant held, completes on ACCESS.
